// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared receiver state encoding and default active geometry
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  localparam int H_DATA_VALID_DEF = 640;
  localparam int V_DATA_VALID_DEF = 480;

  localparam logic [9:0] CNT_MAX = 10'd1023;

endpackage

// File: rtl/vga_rx_sync_edge.sv
// rtl/vga_rx_sync_edge.sv - two-stage capture of HS/VS/blk/Data with edge detection
module vga_rx_sync_edge (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hs,
  input  logic        vs,
  input  logic        blk,
  input  logic [23:0] data,
  output logic        hs_rise,
  output logic        vs_rise,
  output logic        blk_fall,
  output logic        blk1,
  output logic        blk2,
  output logic [23:0] data2
);

  logic        hs1, hs2, vs1, vs2;
  logic [23:0] data1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs1   <= 1'b0;
      hs2   <= 1'b0;
      vs1   <= 1'b0;
      vs2   <= 1'b0;
      blk1  <= 1'b0;
      blk2  <= 1'b0;
      data1 <= '0;
      data2 <= '0;
    end else begin
      hs1   <= hs;
      hs2   <= hs1;
      vs1   <= vs;
      vs2   <= vs1;
      blk1  <= blk;
      blk2  <= blk1;
      data1 <= data;
      data2 <= data1;
    end
  end

  // An edge is a disagreement between the two stages
  assign hs_rise  = hs1 & ~hs2;
  assign vs_rise  = vs1 & ~vs2;
  assign blk_fall = blk2 & ~blk1;

endmodule

// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - VGA timing receiver with lock tracking
// Optional line/frame period measurement: VGA_RX_MEASURE_EN
module vga_timing_rx
  import vga_pkg::*;
#(
  parameter int H_Data_Valid = H_DATA_VALID_DEF,
  parameter int V_Data_Valid = V_DATA_VALID_DEF,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        HS,
  input  logic        VS,
  input  logic        blk,
  input  logic [23:0] Data,
  output logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        sof,
  output logic        eol,
  output logic        locked,
  output logic        err,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total
);

  localparam logic [9:0] H_ACT  = 10'(H_Data_Valid);
  localparam logic [9:0] V_ACT  = 10'(V_Data_Valid);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic        hs_rise, vs_rise, blk_fall, blk1, blk2;
  logic [23:0] data2;

  vga_rx_sync_edge u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .hs       (HS),
    .vs       (VS),
    .blk      (blk),
    .data     (Data),
    .hs_rise  (hs_rise),
    .vs_rise  (vs_rise),
    .blk_fall (blk_fall),
    .blk1     (blk1),
    .blk2     (blk2),
    .data2    (data2)
  );

  logic [9:0] x, y, pix_idx;
  rx_state_t  state, state_nxt;
  logic [3:0] good_cnt, good_cnt_nxt;
  logic       line_err, frame_err, err_nxt, tracking;

  // x counts stage-1 samples, so at blk fall it equals the line length and
  // the pixel sitting in stage 2 has index x-1
  assign pix_idx   = x - 10'd1;
  assign line_err  = blk_fall && (x != H_ACT);
  assign frame_err = vs_rise && ((y != V_ACT) || blk1);
  assign tracking  = (state != SEARCH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x <= '0;
      y <= '0;
    end else begin
      if (blk_fall)                 x <= '0;
      else if (blk1 && x != CNT_MAX) x <= x + 10'd1;
      if (vs_rise)                      y <= '0;
      else if (blk_fall && y != CNT_MAX) y <= y + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    err_nxt      = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_rise) begin
          state_nxt    = TRACK;
          good_cnt_nxt = '0;
        end
      end
      TRACK: begin
        if (line_err || frame_err) begin
          err_nxt   = 1'b1;
          state_nxt = SEARCH;
        end else if (vs_rise) begin
          good_cnt_nxt = good_cnt + 4'd1;
          if (good_cnt + 4'd1 == LOCK_N) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (line_err || frame_err) begin
          err_nxt   = 1'b1;
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      err       <= 1'b0;
      locked    <= 1'b0;
    end else begin
      pix_valid <= blk2 && tracking;
      sof       <= blk2 && tracking && (pix_idx == '0) && (y == '0);
      eol       <= blk_fall && tracking;
      err       <= err_nxt;
      locked    <= (state == LOCKED);
      if (blk2) begin
        pix_data <= data2;
        pix_x    <= pix_idx;
        pix_y    <= y;
      end
    end
  end

`ifdef VGA_RX_MEASURE_EN
  logic [9:0] h_cnt, v_cnt;

  // h_cnt restarts at 1 on the HS edge so it reads the full period at the next one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_total <= '0;
      v_total <= '0;
    end else begin
      if (hs_rise) begin
        h_total <= h_cnt;
        h_cnt   <= 10'd1;
      end else if (h_cnt != CNT_MAX) begin
        h_cnt <= h_cnt + 10'd1;
      end
      if (vs_rise) begin
        v_total <= v_cnt;
        v_cnt   <= {9'd0, hs_rise};
      end else if (hs_rise && v_cnt != CNT_MAX) begin
        v_cnt <= v_cnt + 10'd1;
      end
    end
  end
`else
  logic unused_meas;
  assign unused_meas = hs_rise;
  assign h_total     = '0;
  assign v_total     = '0;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb/tb_vga_timing_rx.sv - directed frame-table bench for vga_timing_rx on a scaled stream
module tb_vga_timing_rx;

  localparam int HA = 16, HFP = 2, HSW = 4, HBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VA = 8, VFP = 1, VSW = 2, VBP = 1;
  localparam int VT = VA + VFP + VSW + VBP;

  logic        clk = 1'b0;
  logic        rstn;
  logic        HS, VS, blk;
  logic [23:0] Data;
  logic [23:0] pix_data;
  logic [9:0]  pix_x, pix_y, h_total, v_total;
  logic        pix_valid, sof, eol, locked, err;
  logic [68:0] outs;

  vga_timing_rx #(.H_Data_Valid(HA), .V_Data_Valid(VA), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rstn(rstn), .HS(HS), .VS(VS), .blk(blk), .Data(Data),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .sof(sof), .eol(eol), .locked(locked), .err(err),
    .h_total(h_total), .v_total(v_total)
  );

  assign outs = {pix_data, pix_x, pix_y, pix_valid, sof, eol, locked, err, h_total, v_total};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_sof = 0, n_eol = 0, n_err = 0, n_err_eol = 0, n_bad = 0;
  int sof_cyc = 0;
  logic [23:0] sof_data = '0;
  logic [9:0]  sof_x = '0, sof_y = '0;

  always @(negedge clk) begin
    if (pix_valid) begin
      n_valid <= n_valid + 1;
      if (!(pix_x == 0 && pix_y == 0) && pix_data != {4'h0, pix_y, pix_x}) n_bad <= n_bad + 1;
    end
    if (sof) begin
      n_sof    <= n_sof + 1;
      sof_cyc  <= cyc;
      sof_data <= pix_data;
      sof_x    <= pix_x;
      sof_y    <= pix_y;
    end
    if (eol) n_eol <= n_eol + 1;
    if (err) n_err <= n_err + 1;
    if (err && eol) n_err_eol <= n_err_eol + 1;
  end

  int n_checks = 0, n_fail = 0;
  int first_drive_cyc = 0;
  int r_valid = 0, r_sof = 0, r_err = 0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one full frame; optionally overrides pixel (0,0) and pulses reset at (rst_pix, rst_line)
  task automatic drive_frame(input int short_line, input int n_lines, input bit use_first,
                             input logic [23:0] first_data, input int rst_line, input int rst_pix);
    for (int l = 0; l < VT; l++) begin
      for (int h = 0; h < HT; h++) begin
        @(posedge clk);
        #1;
        rstn = 1'b1;
        blk  = (l < n_lines) && (h < ((l == short_line) ? HA - 1 : HA));
        HS   = (h >= HA + HFP) && (h < HA + HFP + HSW);
        VS   = (l >= VA + VFP) && (l < VA + VFP + VSW);
        Data = blk ? {4'h0, 10'(l), 10'(h)} : 24'($urandom);
        if (l == 0 && h == 0) begin
          first_drive_cyc = cyc;
          if (use_first) Data = first_data;
        end
        if (l == rst_line && h == rst_pix) begin
          rstn = 1'b0;
          #1;
          check("mid_reset_outputs", outs, '0);
          r_valid = n_valid;
          r_sof   = n_sof;
          r_err   = n_err;
        end
      end
    end
  endtask

  typedef struct {
    int short_line;
    int n_lines;
    int exp_valid;
    int exp_sof;
    int exp_eol;
    int exp_err;
    int exp_err_eol;
    int exp_locked;
  } frame_vec_t;

  frame_vec_t vecs[11];
  int s_valid, s_sof, s_eol, s_err, s_err_eol, s_bad;
  int exp_h, exp_v;

  initial begin
    vecs[0]  = '{-1, 8,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{-1, 8, 128, 1, 8, 0, 0, 0};
    vecs[2]  = '{-1, 8, 128, 1, 8, 0, 0, 1};
    vecs[3]  = '{-1, 8, 128, 1, 8, 0, 0, 1};
    vecs[4]  = '{ 3, 8,  63, 1, 4, 1, 1, 0};
    vecs[5]  = '{-1, 8, 128, 1, 8, 0, 0, 0};
    vecs[6]  = '{-1, 8, 128, 1, 8, 0, 0, 1};
    vecs[7]  = '{-1, 7, 112, 1, 7, 1, 0, 0};
    vecs[8]  = '{-1, 8,   0, 0, 0, 0, 0, 0};
    vecs[9]  = '{-1, 8, 128, 1, 8, 0, 0, 0};
    vecs[10] = '{-1, 8, 128, 1, 8, 0, 0, 1};

    rstn = 1'b0; HS = 1'b1; VS = 1'b1; blk = 1'b1; Data = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs, '0);
    @(posedge clk);
    #1;
    HS = 1'b0; VS = 1'b0; blk = 1'b0; Data = '0; rstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      s_valid = n_valid; s_sof = n_sof; s_eol = n_eol;
      s_err = n_err; s_err_eol = n_err_eol; s_bad = n_bad;
      drive_frame(vecs[i].short_line, vecs[i].n_lines, 1'b0, '0, -1, -1);
      check($sformatf("f%0d_valid", i),   n_valid - s_valid,     vecs[i].exp_valid);
      check($sformatf("f%0d_sof", i),     n_sof - s_sof,         vecs[i].exp_sof);
      check($sformatf("f%0d_eol", i),     n_eol - s_eol,         vecs[i].exp_eol);
      check($sformatf("f%0d_err", i),     n_err - s_err,         vecs[i].exp_err);
      check($sformatf("f%0d_err_eol", i), n_err_eol - s_err_eol, vecs[i].exp_err_eol);
      check($sformatf("f%0d_locked", i),  locked,                vecs[i].exp_locked);
      check($sformatf("f%0d_data", i),    n_bad - s_bad,         0);
    end

`ifdef VGA_RX_MEASURE_EN
    exp_h = HT;
    exp_v = VT;
`else
    exp_h = 0;
    exp_v = 0;
`endif
    check("h_total", h_total, exp_h);
    check("v_total", v_total, exp_v);

    s_sof = n_sof;
    drive_frame(-1, 8, 1'b1, 24'h123456, -1, -1);
    check("sof_count",   n_sof - s_sof, 1);
    check("sof_latency", sof_cyc - (first_drive_cyc + 1), 2);
    check("sof_data",    sof_data, 24'h123456);
    check("sof_xy",      {sof_x, sof_y}, 20'h0);
    check("f11_locked",  locked, 1);

    drive_frame(-1, 8, 1'b0, '0, 4, 8);
    check("post_reset_valid", n_valid - r_valid, 0);
    check("post_reset_sof",   n_sof - r_sof, 0);
    check("post_reset_err",   n_err - r_err, 0);
    check("post_reset_locked", locked, 0);

    s_valid = n_valid; s_sof = n_sof; s_err = n_err;
    drive_frame(-1, 8, 1'b0, '0, -1, -1);
    check("f13_valid",  n_valid - s_valid, 128);
    check("f13_sof",    n_sof - s_sof, 1);
    check("f13_err",    n_err - s_err, 0);
    check("f13_locked", locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL have parameter H_Data_Valid, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter V_Data_Valid, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive good frames needed to declare lock (range 1..15).
REQ-004 SHALL have port clk, input, 1, the single pixel clock; all logic is on its rising edge.
REQ-005 SHALL have port rstn, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have ports HS, VS, blk, each input, 1: sync pulses (active high) and data-valid.
REQ-007 SHALL have port Data, input, 24, pixel RGB; it is meaningful only while blk=1.
REQ-008 SHALL have port pix_data, output, 24: the captured pixel.
REQ-009 SHALL have ports pix_x and pix_y, each output, 10: the pixel coordinates.
REQ-010 SHALL have port pix_valid, output, 1: qualifies pix_data, pix_x and pix_y.
REQ-011 SHALL have ports sof and eol, each output, 1, each a single-cycle pulse: first pixel of frame, last pixel of line.
REQ-012 SHALL have port locked, output, 1: the receiver is in LOCKED state.
REQ-013 SHALL have port err, output, 1: a single-cycle pulse on a timing violation.
REQ-014 SHALL have ports h_total and v_total, output, 10 each: measured clocks per line and lines per frame.

Function
REQ-015 SHALL register HS/VS/blk/Data through one input stage, then a second stage; edges are detected as stage1 != stage2.
REQ-016 SHALL present pix_* exactly 2 clocks after the blk/Data sample they represent.
REQ-017 SHALL keep an active-pixel counter x: it increments per blk=1 sample, clears on blk falling edge, and saturates at 1023.
REQ-018 SHALL keep a line counter y: it increments on each blk falling edge, clears on VS rising edge, and saturates at 1023.
REQ-019 SHALL drive pix_valid=blk(delayed) only when state != SEARCH; pix_x=x and pix_y=y for that pixel.
REQ-020 SHALL pulse sof with the pixel at x=0,y=0, and pulse eol with the pixel where blk falls next sample.
REQ-021 SHALL implement an FSM with states SEARCH, TRACK and LOCKED.
REQ-022 SHALL treat it as a line error when a blk falling edge occurs with x != H_Data_Valid.
REQ-023 SHALL treat it as a frame error when a VS rising edge occurs with y != V_Data_Valid, or with blk=1.
REQ-024 SHALL transition SEARCH->TRACK on the first VS rising edge; the good-frame count is set to 0 and no error is checked on this edge.
REQ-025 SHALL, in TRACK, increment the good-frame count on each error-free VS rising edge, and go to LOCKED when the count reaches LOCK_FRAMES.
REQ-026 SHALL, on any line or frame error in TRACK or LOCKED, pulse err once and go to SEARCH; simultaneous line and frame errors produce one pulse.
REQ-027 SHALL assert locked on the clock after entering LOCKED and deassert it on the clock after leaving.
REQ-028 SHALL ignore errors while in SEARCH (err=0).

Reset
REQ-029 SHALL, while rstn=0, set every output to 0, the state to SEARCH, and all counters and pipeline stages to 0.
REQ-030 SHALL apply reset asserted mid-frame immediately; after release, lock requires a fresh SEARCH->TRACK sequence.

Configuration
REQ-031 SHALL, with VGA_RX_MEASURE_EN defined, count clocks between HS rising edges into h_total and lines between VS rising edges into v_total, each saturating at 1023 and updated at the closing edge.
REQ-032 SHALL, without VGA_RX_MEASURE_EN, tie h_total and v_total to 0 and synthesize no measurement counters; all other behaviour is unchanged.

Structure
REQ-033 SHALL place the FSM state encoding and the default H_Data_Valid/V_Data_Valid constants in shared package vga_pkg.
REQ-034 SHALL use one sub-module, vga_rx_sync_edge: the two-stage input registers plus rise/fall detection for HS, VS and blk.

Verification
REQ-035 SHALL cover: a standard 800x525-clock stream (HS 96, VS 2 lines, 640x480 active) -> locked=1 after the 3rd VS rising edge, with err never asserted.
REQ-036 SHALL cover: the first active pixel Data=24'h123456 -> pix_data=24'h123456, pix_x=0, pix_y=0, sof=1, exactly 2 clocks later.
REQ-037 SHALL cover: line 100 shortened to 639 active pixels while locked -> one err pulse at its eol, then locked=0 and pix_valid=0 until the next VS.
REQ-038 SHALL cover: a frame with 479 active lines -> err at VS rising edge, state SEARCH, and relock after 2 further good frames.
REQ-039 SHALL cover: rstn pulled low at pixel (320,240) -> all outputs 0 within the same cycle, and no sof until after the next VS.
REQ-040 SHALL cover: with VGA_RX_MEASURE_EN, the standard stream -> h_total=800 and v_total=525; without it, both read 0.
